npu_cfg_loader: RTL and testbench
=================================

NPU_CFG_LOADER -- requirements
Module: npu_cfg_loader

Interface
REQ-001 Parameters SHALL be: ADDR_W, default 10, ROM word-address width; DATA_W, default 32, config word width.
REQ-002 Port CLK SHALL be an input, 1 bit wide, and carry the single system clock; all state changes on its rising edge.
REQ-003 Port RST SHALL be an input, 1 bit wide, and be the synchronous, active-high reset.
REQ-004 Port start SHALL be an input, 1 bit wide, and be a single-cycle request to begin a load.
REQ-005 Port cfg_base SHALL be an input, ADDR_W bits wide, and give the first ROM address, sampled with start.
REQ-006 Port cfg_len SHALL be an input, ADDR_W bits wide, and give the number of words to load, sampled with start.
REQ-007 Port rom_addr SHALL be an output, ADDR_W bits wide, registered, and give the ROM read address.
REQ-008 Port rom_data SHALL be an input, DATA_W bits wide, and carry ROM read data, valid 1 cycle after rom_addr is sampled.
REQ-009 Port npu_config_data SHALL be an output, DATA_W bits wide, registered, and carry the word presented to the NPU config FIFO.
REQ-010 Port npu_config_fifo_write_enable SHALL be an output, 1 bit wide, and be the write strobe to the NPU config FIFO.
REQ-011 Port npu_config_fifo_full SHALL be an input, 1 bit wide, and be the full flag from the NPU config FIFO.
REQ-012 Port busy SHALL be an output, 1 bit wide, and be high while in FETCH, LATCH or WRITE.
REQ-013 Port done SHALL be an output, 1 bit wide, and be a 1-cycle pulse when a load completes.
REQ-014 Port words_written SHALL be an output, ADDR_W bits wide, and count the words accepted in the current or most recent load.

Function
REQ-015 The FSM SHALL have the states IDLE, FETCH, LATCH, WRITE and DONE.
REQ-016 In IDLE, start=1 SHALL latch cfg_base into idx and cfg_len into remaining, clear words_written, and go to FETCH (cfg_len≠0) or DONE (cfg_len=0).
REQ-017 start SHALL be ignored in every state other than IDLE; a pending load is not queued.
REQ-018 FETCH SHALL last 1 cycle: rom_addr<=idx, then go to LATCH.
REQ-019 LATCH SHALL last 1 cycle: at the end of the cycle, npu_config_data<=rom_data, then go to WRITE.
REQ-020 In WRITE, npu_config_fifo_write_enable SHALL equal NOT npu_config_fifo_full (combinational) and be 0 in all other states.
REQ-021 In WRITE with full=0, on the edge: idx<=idx+1 modulo 2^ADDR_W, remaining<=remaining-1, words_written<=words_written+1; go to DONE if remaining=1, else FETCH.
REQ-022 In WRITE with full=1, all state SHALL hold and npu_config_data SHALL stay stable until full drops; there is no timeout.
REQ-023 Throughput SHALL be 3 cycles per word when full never asserts; first write strobe 3 cycles after the start edge.
REQ-024 Address wrap SHALL be silent: cfg_base+k past 2^ADDR_W-1 continues from 0.
REQ-025 DONE SHALL last 1 cycle with done=1, busy=0, then go to IDLE; words_written SHALL hold its value until the next accepted start.
REQ-026 Exactly cfg_len write strobes SHALL occur per load, in ascending (wrapped) address order, each word written exactly once.

Reset
REQ-027 RST=1 SHALL take priority over all other inputs, including start on the same edge.
REQ-028 On reset: state=IDLE, rom_addr=0, npu_config_data=0, write_enable=0, busy=0, done=0, words_written=0, idx=0, remaining=0.
REQ-029 Reset mid-load SHALL abort with no further write strobes from the following cycle; a partially loaded FIFO is the NPU's responsibility (it resets on the same RST).

Verification
REQ-030 Scenario basic load: cfg_base=0, cfg_len=4, ROM[i]=0xA0000000+i, full=0 -> strobes at cycles 3, 6, 9, 12 after start, with data A0000000..A0000003, then done at cycle 13 and words_written=4.
REQ-031 Scenario backpressure: full held 1 for 5 cycles when the second word reaches WRITE -> write_enable=0 and data=ROM[1] stable throughout; strobe in the cycle full drops; total 4 strobes, no duplicates.
REQ-032 Scenario wrap: cfg_base=0x3FE, cfg_len=4 -> rom_addr sequence 0x3FE, 0x3FF, 0x000, 0x001.
REQ-033 Scenario zero length: cfg_len=0 -> no strobe, done 1 cycle after start, busy never high, words_written=0.
REQ-034 Scenario reset/ignored start: start re-pulsed while busy -> ignored; RST asserted after the 2nd strobe -> all outputs at reset values next cycle, no further strobes; a new start then performs a full load.

Source files
------------

// File: rtl/npu_cfg_loader.sv
// Streams a block of configuration words from a synchronous ROM into the NPU
// config FIFO, one word every three cycles, stalling while the FIFO is full.
module npu_cfg_loader #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              start,
    input  logic [ADDR_W-1:0] cfg_base,
    input  logic [ADDR_W-1:0] cfg_len,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_data,
    output logic [DATA_W-1:0] npu_config_data,
    output logic              npu_config_fifo_write_enable,
    input  logic              npu_config_fifo_full,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] words_written,
    output logic [2:0]        dbg_state_o
);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] FETCH = 3'd1;
    localparam logic [2:0] LATCH = 3'd2;
    localparam logic [2:0] WRITE = 3'd3;
    localparam logic [2:0] DONE  = 3'd4;

    logic [2:0]        state_q, state_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [ADDR_W-1:0] remaining_q, remaining_d;
    logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [ADDR_W-1:0] words_q, words_d;

    // FIFO handshake: write_enable is the valid, !full is the ready; a word
    // transfers on any edge where write_enable is high, and write_enable only
    // rises in WRITE, so it already implies ready.
    assign npu_config_fifo_write_enable = (state_q == WRITE) && !npu_config_fifo_full;

    assign busy            = (state_q == FETCH) || (state_q == LATCH) || (state_q == WRITE);
    assign done            = (state_q == DONE);
    assign rom_addr        = rom_addr_q;
    assign npu_config_data = data_q;
    assign words_written   = words_q;
    assign dbg_state_o     = state_q;

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        remaining_d = remaining_q;
        rom_addr_d  = rom_addr_q;
        data_d      = data_q;
        words_d     = words_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    idx_d       = cfg_base;
                    remaining_d = cfg_len;
                    words_d     = '0;
                    state_d     = (cfg_len == '0) ? DONE : FETCH;
                end
            end
            FETCH: begin
                rom_addr_d = idx_q;
                state_d    = LATCH;
            end
            LATCH: begin
                // ROM data for the address launched in FETCH is valid now.
                data_d  = rom_data;
                state_d = WRITE;
            end
            WRITE: begin
                if (!npu_config_fifo_full) begin
                    idx_d       = idx_q + ADDR_W'(1);
                    remaining_d = remaining_q - ADDR_W'(1);
                    words_d     = words_q + ADDR_W'(1);
                    state_d     = (remaining_q == ADDR_W'(1)) ? DONE : FETCH;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            remaining_q <= '0;
            rom_addr_q  <= '0;
            data_q      <= '0;
            words_q     <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            remaining_q <= remaining_d;
            rom_addr_q  <= rom_addr_d;
            data_q      <= data_d;
            words_q     <= words_d;
        end
    end

endmodule

// File: tb/tb_npu_cfg_loader.sv
// Directed bench for npu_cfg_loader: ROM model, strobe logger and
// scoreboard comparing each load against hand-computed words and timing.
module tb_npu_cfg_loader;

    logic        CLK = 1'b0;
    logic        RST;
    logic        start;
    logic [9:0]  cfg_base;
    logic [9:0]  cfg_len;
    logic [9:0]  rom_addr;
    logic [31:0] rom_data;
    logic [31:0] npu_config_data;
    logic        we;
    logic        full;
    logic        busy;
    logic        done;
    logic [9:0]  words_written;
    logic [2:0]  dbg_state;

    logic [31:0] rom [0:1023];

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int start_ref = 0;
    int done_rel = -1;
    int done_cnt = 0;
    bit busy_seen = 1'b0;

    logic [31:0] exp_q[$];
    logic [31:0] exp_addr_q[$];
    logic [31:0] got_data_q[$];
    logic [31:0] got_addr_q[$];
    int          got_cyc_q[$];

    npu_cfg_loader #(.ADDR_W(10), .DATA_W(32)) dut (
        .CLK                          (CLK),
        .RST                          (RST),
        .start                        (start),
        .cfg_base                     (cfg_base),
        .cfg_len                      (cfg_len),
        .rom_addr                     (rom_addr),
        .rom_data                     (rom_data),
        .npu_config_data              (npu_config_data),
        .npu_config_fifo_write_enable (we),
        .npu_config_fifo_full         (full),
        .busy                         (busy),
        .done                         (done),
        .words_written                (words_written),
        .dbg_state_o                  (dbg_state)
    );

    // clock / ROM model
    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;
    assign rom_data = rom[rom_addr];

    // strobe logger, sampled mid-cycle
    always @(negedge CLK) begin
        if (we) begin
            got_data_q.push_back(npu_config_data);
            got_addr_q.push_back({22'd0, rom_addr});
            got_cyc_q.push_back(cyc - start_ref + 1);
        end
        if (done) begin
            done_rel = cyc - start_ref + 1;
            done_cnt++;
        end
        if (busy) busy_seen = 1'b1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic start_load(input logic [9:0] b, input logic [9:0] l);
        @(posedge CLK); #1;
        got_data_q.delete(); got_addr_q.delete(); got_cyc_q.delete();
        exp_q.delete(); exp_addr_q.delete();
        for (int k = 0; k < int'(l); k++) begin
            logic [9:0] a;
            a = b + 10'(k);
            exp_q.push_back(32'hA000_0000 + {22'd0, a});
            exp_addr_q.push_back({22'd0, a});
        end
        done_rel = -1; done_cnt = 0; busy_seen = 1'b0;
        start = 1'b1; cfg_base = b; cfg_len = l;
        @(posedge CLK); #1;
        start = 1'b0;
        start_ref = cyc;
    endtask

    task automatic wait_done(input int budget);
        int n;
        n = 0;
        while (done_cnt == 0 && n < budget) begin
            @(negedge CLK); #1;
            n++;
        end
        check("done_timeout", {31'd0, done_cnt == 0}, 32'd0);
        repeat (3) @(posedge CLK);
        #1;
    endtask

    // scoreboard: strobe count, data, address and cycle of each strobe
    task automatic compare_log(input string tag, input int len, input int bp);
        int exp_cyc;
        check({tag, "_strobes"}, got_data_q.size(), len);
        for (int k = 0; k < len && got_data_q.size() > 0; k++) begin
            if (bp != 0) exp_cyc = (k == 0) ? 3 : 8 + 3 * k;
            else         exp_cyc = 3 + 3 * k;
            check({tag, "_data"}, got_data_q.pop_front(), exp_q.pop_front());
            check({tag, "_addr"}, got_addr_q.pop_front(), exp_addr_q.pop_front());
            check({tag, "_cyc"}, got_cyc_q.pop_front(), exp_cyc);
        end
        check({tag, "_done_cnt"}, done_cnt, 1);
        check({tag, "_ww"}, {22'd0, words_written}, len);
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) rom[i] = 32'hA000_0000 + i;
        RST = 1'b1; start = 1'b0; cfg_base = '0; cfg_len = '0; full = 1'b0;

        // reset with a simultaneous start: reset must win
        repeat (2) @(posedge CLK);
        #1; start = 1'b1; cfg_len = 10'd4;
        @(posedge CLK); #1; start = 1'b0;
        @(negedge CLK);
        check("rst_state", {29'd0, dbg_state}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_we", {31'd0, we}, 32'd0);
        check("rst_addr", {22'd0, rom_addr}, 32'd0);
        check("rst_data", npu_config_data, 32'd0);
        check("rst_ww", {22'd0, words_written}, 32'd0);
        @(posedge CLK); #1; RST = 1'b0;

        // basic load
        start_load(10'd0, 10'd4);
        wait_done(40);
        compare_log("basic", 4, 0);
        check("basic_done_rel", done_rel, 13);

        // backpressure on the second word
        start_load(10'h010, 10'd4);
        repeat (5) @(posedge CLK);
        #1; full = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge CLK);
            check("bp_we_low", {31'd0, we}, 32'd0);
            check("bp_data_hold", npu_config_data, 32'hA000_0011);
        end
        @(posedge CLK); #1; full = 1'b0;
        wait_done(60);
        compare_log("bp", 4, 1);
        check("bp_done_rel", done_rel, 18);

        // address wrap
        start_load(10'h3FE, 10'd4);
        wait_done(40);
        compare_log("wrap", 4, 0);

        // zero length
        start_load(10'h055, 10'd0);
        wait_done(10);
        compare_log("zero", 0, 0);
        check("zero_done_rel", done_rel, 1);
        check("zero_busy", {31'd0, busy_seen}, 32'd0);

        // ignored re-start, then reset after the second strobe
        start_load(10'h020, 10'd6);
        repeat (3) @(posedge CLK);
        #1; start = 1'b1; cfg_base = 10'h100; cfg_len = 10'd2;
        @(posedge CLK); #1; start = 1'b0;
        repeat (2) @(posedge CLK);
        #1; RST = 1'b1;
        @(negedge CLK);
        @(negedge CLK);
        check("abort_state", {29'd0, dbg_state}, 32'd0);
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_we", {31'd0, we}, 32'd0);
        check("abort_addr", {22'd0, rom_addr}, 32'd0);
        check("abort_data", npu_config_data, 32'd0);
        check("abort_ww", {22'd0, words_written}, 32'd0);
        @(posedge CLK); #1; RST = 1'b0;
        repeat (10) @(posedge CLK);
        check("abort_strobes", got_data_q.size(), 2);
        check("abort_no_done", done_cnt, 0);
        for (int k = 0; k < 2 && got_data_q.size() > 0; k++)
            check("abort_data_seq", got_data_q.pop_front(), exp_q.pop_front());

        // fresh load after reset
        start_load(10'h030, 10'd3);
        wait_done(40);
        compare_log("post_rst", 3, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
